nes_joypad_port: RTL and testbench
==================================

# nes_joypad_port

Emulates the two NES standard-controller ports ($4016/$4017) on the CPU register bus, on the responding side of the same `cs`/`rw`/address/data interface that the CPU-side driver uses toward the PPU. USB HID keycodes from the MicroBlaze keycode GPIO are mapped to two 8-button pads. Each pad is latched by the $4016 strobe and shifted out serially, one bit per CPU read, exactly as the 4021 shift registers in a real controller behave. The block sits on the CPU clock domain next to `PPU_driver`.

## Interface
Parameters:
- `BLOCK_OPPOSING`, 1: when 1, Up+Down both held reports neither; Left+Right both held reports neither.
- `OPEN_BUS`, 8'h40: value driven on data bits 7:1 of every read.

Ports:
- `clk` in 1: CPU clock.
- `reset` in 1: synchronous, active-high reset.
- `keycodes` in 32: four HID keycodes {k3,k2,k1,k0}, 8 bits each; 8'h00 = none.
- `cs` in 1: access strobe; one access per cycle in which it is high.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 1: 0 = $4016, 1 = $4017.
- `data_in` in 8: write data.
- `data_out` out 8: registered read data.
- `buttons_p1` out 8: current mapped P1 buttons, for debug/hex.
- `buttons_p2` out 8: current mapped P2 buttons, for debug/hex.

## Operation
- Button bit order, for both pads and serial order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right. 1 = pressed.
- P1 mapping: A=8'h1B (X), B=8'h1D (Z), Select=8'h2B (Tab), Start=8'h28 (Enter), Up=8'h52, Down=8'h51, Left=8'h50, Right=8'h4F.
- P2 mapping: A=8'h0B (H), B=8'h0A (G), Select=8'h17 (T), Start=8'h1C (Y), Up=8'h1A (W), Down=8'h16 (S), Left=8'h04 (A), Right=8'h07 (D).
- A button is pressed if any of the four keycode slots equals its code. Duplicate codes have no extra effect.
- Opposing-direction filter is applied after mapping, when `BLOCK_OPPOSING`=1.
- The filtered result is registered into `buttons_p1`/`buttons_p2` (the button stage).
- State:
  - `strobe` (1 bit).
  - `sr1`, `sr2` (8 bits each).
  - `data_out` register.
- Write ($4016): `strobe` <= `data_in[0]`. The same edge loads `sr1`<=`buttons_p1` and `sr2`<=`buttons_p2`, regardless of the value written.
- Write ($4017): ignored. It belongs to the APU frame counter and causes no state change.
- While `strobe`=1: `sr1`/`sr2` reload from the button stage every cycle.
- Read ($4016): `data_out` <= `OPEN_BUS[7:1]`, `sr1[0]`.
  - If `strobe`=0: `sr1` <= {1'b1, `sr1[7:1]`}.
  - If `strobe`=1: no shift, so A is returned repeatedly.
- Read ($4017): the same as a $4016 read, using `sr2`. `sr1` is untouched.
- After 8 shifts with no new latch, reads return bit0=1 indefinitely, because 1s are shifted in.
- `data_out` holds its value between reads. Writes and idle cycles do not change it.

## Timing
- Reset values (synchronous):
  - `strobe`=0.
  - `sr1`=`sr2`=8'hFF.
  - `buttons_p1`=`buttons_p2`=8'h00.
  - `data_out`=8'h00.
- Keycode change to `buttons_pX`: 1 cycle.
- Keycode change to the serial stream: 2 cycles when `strobe` is held at 1.
- Read latency: `data_out` is valid on the cycle after the `cs`/`rw`=1 cycle, and is held thereafter.
- Back-to-back reads on consecutive cycles are legal. Each read shifts once.
- Strobe 1→0 write: the final latch captures `buttons_pX` as registered at that edge. Later key changes are ignored until the next $4016 write.
- Reset asserted mid-sequence: all state returns to reset values on that edge. Any `cs` in the same cycle is ignored.

## Test plan
- Reset, then read $4016 with no write: `data_out`=8'h41 on each of the first 3 reads. This is because `sr1` resets to 8'hFF.
- keycodes=32'h0000_001B (X → P1 A). Write $4016=1, then $4016=0, then 9 reads of $4016. Required bit0 sequence: 1,0,0,0,0,0,0,0,1 (`data_out` 8'h41/8'h40).
- keycodes=32'h4F28_1A00 (P1 Right and Start, P2 Up). Strobe 1→0. Read $4016 ×8: bit0 = 0,0,0,1,0,0,0,1. Read $4017 ×8: bit0 = 0,0,0,0,1,0,0,0. Interleaved reads must not disturb the other pad's sequence.
- Strobe held at 1, keycodes change from 0 to 8'h1B: $4016 reads return 8'h40 until 2 cycles after the change, then 8'h41 on every read with no shifting.
- `BLOCK_OPPOSING`=1, keycodes=32'h0000_5251 (Up and Down held): `buttons_p1`=8'h00. With the parameter at 0, `buttons_p1`=8'h30.
- Write $4017=8'hFF, then reset asserted in the middle of a shift sequence: `strobe` is unaffected by the $4017 write, and after reset all outputs match the reset values.

Source files
------------

// File: rtl/nes_joypad_port.sv
// NES standard-controller ports ($4016/$4017): maps USB HID keycodes onto two
// 8-button pads and shifts them out one bit per CPU read, like the pad's 4021.
module nes_joypad_port #(
  parameter bit         BLOCK_OPPOSING = 1'b1,
  parameter logic [7:0] OPEN_BUS       = 8'h40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] keycodes,
  input  logic        cs,
  input  logic        rw,
  input  logic        addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  buttons_p1,
  output logic [7:0]  buttons_p2
);

  // Keycode per button, button 0 (A) in the low byte.
  localparam logic [63:0] P1_CODES = {8'h4F, 8'h50, 8'h51, 8'h52, 8'h28, 8'h2B, 8'h1D, 8'h1B};
  localparam logic [63:0] P2_CODES = {8'h07, 8'h04, 8'h16, 8'h1A, 8'h1C, 8'h17, 8'h0A, 8'h0B};

  function automatic logic [7:0] map_pad(input logic [31:0] kc, input logic [63:0] codes);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 4; s++) begin
        b[i] = b[i] | (kc[8*s +: 8] == codes[8*i +: 8]);
      end
    end
    return b;
  endfunction

  // Up+Down or Left+Right held together report neither direction of that pair.
  function automatic logic [7:0] filter_opposing(input logic [7:0] b);
    logic [7:0] f;
    f = b;
    if (BLOCK_OPPOSING) begin
      f[5:4] = (b[4] & b[5]) ? 2'b00 : b[5:4];
      f[7:6] = (b[6] & b[7]) ? 2'b00 : b[7:6];
    end else begin
      f = b;
    end
    return f;
  endfunction

  logic [7:0] p1_map_s;
  logic [7:0] p2_map_s;
  logic       wr_4016_s;
  logic       rd_4016_s;
  logic       rd_4017_s;
  logic       strobe_r;
  logic [7:0] sr1_r;
  logic [7:0] sr2_r;

  // Combinational keycode-to-pad mapping and bus decode.
  always_comb begin
    p1_map_s  = filter_opposing(map_pad(keycodes, P1_CODES));
    p2_map_s  = filter_opposing(map_pad(keycodes, P2_CODES));
    wr_4016_s = cs & ~rw & ~addr;
    rd_4016_s = cs & rw & ~addr;
    rd_4017_s = cs & rw & addr;
  end

  // Button stage, strobe, shift registers and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      buttons_p1 <= 8'h00;
      buttons_p2 <= 8'h00;
      strobe_r   <= 1'b0;
      sr1_r      <= 8'hFF;
      sr2_r      <= 8'hFF;
      data_out   <= 8'h00;
    end else begin
      buttons_p1 <= p1_map_s;
      buttons_p2 <= p2_map_s;

      // Any $4016 write latches, whatever value is written; $4017 writes are the APU's.
      if (wr_4016_s) begin
        strobe_r <= data_in[0];
        sr1_r    <= buttons_p1;
        sr2_r    <= buttons_p2;
      end else if (strobe_r) begin
        sr1_r <= buttons_p1;
        sr2_r <= buttons_p2;
      end else begin
        sr1_r <= rd_4016_s ? {1'b1, sr1_r[7:1]} : sr1_r;
        sr2_r <= rd_4017_s ? {1'b1, sr2_r[7:1]} : sr2_r;
      end

      if (rd_4016_s) begin
        data_out <= {OPEN_BUS[7:1], sr1_r[0]};
      end else if (rd_4017_s) begin
        data_out <= {OPEN_BUS[7:1], sr2_r[0]};
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: directed scenarios plus random bus traffic checked
// against a queue-based model of the two controller ports.
module tb_nes_joypad_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] keycodes;
  logic        cs;
  logic        rw;
  logic        addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  buttons_p1;
  logic [7:0]  buttons_p2;
  logic [7:0]  nb_data_out;
  logic [7:0]  nb_buttons_p1;
  logic [7:0]  nb_buttons_p2;

  int errors = 0;
  int checks = 0;

  logic [7:0] p1_tab [8] = '{8'h1B, 8'h1D, 8'h2B, 8'h28, 8'h52, 8'h51, 8'h50, 8'h4F};
  logic [7:0] p2_tab [8] = '{8'h0B, 8'h0A, 8'h17, 8'h1C, 8'h1A, 8'h16, 8'h04, 8'h07};

  // Model: each port is a queue of bits still to come; an empty queue reads as 1.
  bit         q1 [$];
  bit         q2 [$];
  logic       m_strobe;
  logic [7:0] m_b1;
  logic [7:0] m_b2;
  logic [7:0] m_do;

  nes_joypad_port dut (
    .clk(clk), .reset(reset), .keycodes(keycodes), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .buttons_p1(buttons_p1), .buttons_p2(buttons_p2)
  );

  nes_joypad_port #(.BLOCK_OPPOSING(1'b0), .OPEN_BUS(8'h40)) dut_nb (
    .clk(clk), .reset(reset), .keycodes(keycodes), .cs(cs), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(nb_data_out), .buttons_p1(nb_buttons_p1), .buttons_p2(nb_buttons_p2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pad(input logic [31:0] kc, input int player, input bit blk);
    logic [7:0] b;
    logic [7:0] code;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      code = (player == 1) ? p1_tab[i] : p2_tab[i];
      for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == code) b[i] = 1'b1;
    end
    if (blk && b[4] && b[5]) b[5:4] = 2'b00;
    if (blk && b[6] && b[7]) b[7:6] = 2'b00;
    return b;
  endfunction

  task automatic load_queues();
    q1.delete();
    q2.delete();
    for (int i = 0; i < 8; i++) begin
      q1.push_back(m_b1[i]);
      q2.push_back(m_b2[i]);
    end
  endtask

  // One clock: advance the model from the current inputs, then let the DUT take the edge.
  task automatic step();
    bit b;
    if (reset) begin
      m_strobe = 1'b0; m_b1 = 8'h00; m_b2 = 8'h00; m_do = 8'h00;
      q1.delete(); q2.delete();
    end else begin
      if (cs && !rw && !addr) begin
        m_strobe = data_in[0];
        load_queues();
      end else begin
        if (cs && rw) begin
          if (!addr) begin
            b = (q1.size() > 0) ? q1[0] : 1'b1;
            if (!m_strobe && q1.size() > 0) void'(q1.pop_front());
          end else begin
            b = (q2.size() > 0) ? q2[0] : 1'b1;
            if (!m_strobe && q2.size() > 0) void'(q2.pop_front());
          end
          m_do = 8'h40 | {7'd0, b};
        end
        if (m_strobe) load_queues();
      end
      m_b1 = pad(keycodes, 1, 1'b1);
      m_b2 = pad(keycodes, 2, 1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0; rw = 1'b1; addr = 1'b0; data_in = 8'h00;
    step();
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    step();
    cs = 1'b0;
  endtask

  task automatic rd(input logic a);
    cs = 1'b1; rw = 1'b1; addr = a; data_in = 8'h00;
    step();
    cs = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; keycodes = 32'h0; cs = 1'b0; rw = 1'b1; addr = 1'b0; data_in = 8'h00;
    step(); step();
    reset = 1'b0;
    checks++;
    if (data_out !== 8'h00 || buttons_p1 !== 8'h00 || buttons_p2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got do=%h p1=%h p2=%h want 00/00/00", data_out, buttons_p1, buttons_p2);
    end
    for (int i = 0; i < 3; i++) begin
      rd(1'b0);
      checks++;
      if (data_out !== 8'h41) begin
        errors++;
        $display("FAIL reset_read%0d: got %h want 41", i, data_out);
      end
    end
  endtask

  task automatic test_single_a();
    bit exp [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    keycodes = 32'h0000_001B;
    idle();
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      rd(1'b0);
      checks++;
      if (data_out !== (8'h40 | {7'd0, exp[i]})) begin
        errors++;
        $display("FAIL single_a_read%0d: got %h want %h", i, data_out, 8'h40 | {7'd0, exp[i]});
      end
    end
    idle();
    checks++;
    if (data_out !== 8'h41) begin
      errors++;
      $display("FAIL hold_after_idle: got %h want 41", data_out);
    end
  endtask

  task automatic test_two_pads();
    bit e1 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit e2 [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    keycodes = 32'h4F28_1A00;
    idle();
    checks++;
    if (buttons_p1 !== 8'h88 || buttons_p2 !== 8'h10) begin
      errors++;
      $display("FAIL two_pads_buttons: got %h/%h want 88/10", buttons_p1, buttons_p2);
    end
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    keycodes = 32'h0;
    for (int i = 0; i < 8; i++) begin
      rd(1'b0);
      checks++;
      if (data_out[0] !== e1[i] || data_out[7:1] !== 7'h20) begin
        errors++;
        $display("FAIL p1_bit%0d: got %h want bit0=%0d", i, data_out, e1[i]);
      end
      rd(1'b1);
      checks++;
      if (data_out[0] !== e2[i] || data_out[7:1] !== 7'h20) begin
        errors++;
        $display("FAIL p2_bit%0d: got %h want bit0=%0d", i, data_out, e2[i]);
      end
    end
  endtask

  task automatic test_strobe_held();
    logic [7:0] exp [6] = '{8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
    keycodes = 32'h0;
    idle(); idle();
    wr(1'b0, 8'h01);
    rd(1'b0);
    checks++;
    if (data_out !== exp[0]) begin
      errors++;
      $display("FAIL strobe_pre: got %h want %h", data_out, exp[0]);
    end
    keycodes = 32'h0000_001B;
    for (int i = 1; i < 6; i++) begin
      rd(1'b0);
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL strobe_held_read%0d: got %h want %h", i, data_out, exp[i]);
      end
    end
    wr(1'b0, 8'h00);
  endtask

  task automatic test_opposing();
    keycodes = 32'h0000_5251;
    idle();
    checks++;
    if (buttons_p1 !== 8'h00 || nb_buttons_p1 !== 8'h30) begin
      errors++;
      $display("FAIL opposing_ud: got %h/%h want 00/30", buttons_p1, nb_buttons_p1);
    end
    keycodes = 32'h0B04_0750;
    idle();
    checks++;
    if (buttons_p1 !== 8'h40 || buttons_p2 !== 8'h01 || nb_buttons_p2 !== 8'hC1) begin
      errors++;
      $display("FAIL opposing_lr: got %h/%h/%h want 40/01/C1", buttons_p1, buttons_p2, nb_buttons_p2);
    end
  endtask

  task automatic test_4017_write_and_reset();
    keycodes = 32'h0000_001D;
    idle();
    wr(1'b0, 8'h01);
    wr(1'b0, 8'h00);
    wr(1'b1, 8'hFF);
    rd(1'b0);
    rd(1'b0);
    checks++;
    if (data_out !== 8'h41) begin
      errors++;
      $display("FAIL write_4017_no_strobe: got %h want 41", data_out);
    end
    rd(1'b0);
    checks++;
    if (data_out !== 8'h40) begin
      errors++;
      $display("FAIL after_4017_shift: got %h want 40", data_out);
    end
    reset = 1'b1; cs = 1'b1; rw = 1'b1; addr = 1'b0;
    step();
    reset = 1'b0; cs = 1'b0;
    checks++;
    if (data_out !== 8'h00 || buttons_p1 !== 8'h00 || buttons_p2 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got do=%h p1=%h p2=%h want 00/00/00", data_out, buttons_p1, buttons_p2);
    end
    rd(1'b0);
    checks++;
    if (data_out !== 8'h41 || buttons_p1 !== 8'h02) begin
      errors++;
      $display("FAIL post_reset_read: got do=%h p1=%h want 41/02", data_out, buttons_p1);
    end
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'($urandom);
      2: return p1_tab[$urandom_range(0, 7)];
      default: return p2_tab[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] kc;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        keycodes = {rand_key(), rand_key(), rand_key(), rand_key()};
      kc = keycodes;
      reset = ($urandom_range(0, 99) == 0);
      cs = ($urandom_range(0, 2) != 0);
      rw = ($urandom_range(0, 3) != 0);
      addr = $urandom_range(0, 1);
      data_in = 8'($urandom);
      step();
      checks++;
      if (data_out !== m_do || buttons_p1 !== m_b1 || buttons_p2 !== m_b2) begin
        errors++;
        $display("FAIL random_cycle%0d: got do=%h p1=%h p2=%h want %h/%h/%h",
                 n, data_out, buttons_p1, buttons_p2, m_do, m_b1, m_b2);
      end
      checks++;
      if (nb_buttons_p1 !== (reset ? 8'h00 : pad(kc, 1, 1'b0))) begin
        errors++;
        $display("FAIL random_noblock%0d: got %h want %h", n, nb_buttons_p1,
                 reset ? 8'h00 : pad(kc, 1, 1'b0));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_two_pads();
    test_strobe_held();
    test_opposing();
    test_4017_write_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
